// File: rtl/mac_result_collector.sv
// mac_result_collector: sums every ACC_LEN valid results into a block sum and buffers the sums
// in a FIFO drained by valid/ready. Optional macro MAC_COLLECTOR_DROPCNT_EN adds drop_count.
package params_pkg;
    localparam int OUTPUT_SIZE = 16;
endpackage

module mac_result_collector
    import params_pkg::*;
#(
    parameter int ACC_LEN    = 4,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                                                          clock,
    input  logic                                                          reset,
    input  logic                                                          in_valid,
    input  logic [OUTPUT_SIZE-1:0]                                        in_data,
    input  logic                                                          flush,
    output logic                                                          out_valid,
    input  logic                                                          out_ready,
    output logic [OUTPUT_SIZE+$clog2(ACC_LEN)+((ACC_LEN == 1) ? 1 : 0)-1:0] out_sum,
    output logic [$clog2(ACC_LEN+1)-1:0]                                  out_count,
    output logic                                                          overflow
`ifdef MAC_COLLECTOR_DROPCNT_EN
    ,
    output logic [15:0]                                                   drop_count
`endif
);

    localparam int SUM_W = OUTPUT_SIZE + $clog2(ACC_LEN) + ((ACC_LEN == 1) ? 1 : 0);
    localparam int CNT_W = $clog2(ACC_LEN + 1);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] ACC_LEN_C = CNT_W'(ACC_LEN);

    typedef enum logic {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [SUM_W-1:0]   r_acc;
    logic [CNT_W-1:0]   r_cnt;
    logic [SUM_W-1:0]   w_acc_sum;
    logic [CNT_W-1:0]   w_cnt_sum;
    logic               w_close;
    logic               w_pop;
    logic               w_push;
    logic               w_drop;
    logic               w_full;
    logic               w_empty;
    logic [PTR_W:0]     r_wptr;
    logic [PTR_W:0]     r_rptr;
    logic               r_overflow;
    logic [SUM_W-1:0]   r_mem_sum [FIFO_DEPTH];
    logic [CNT_W-1:0]   r_mem_cnt [FIFO_DEPTH];

    // Accumulate stage: the incoming sample is folded in before deciding whether the block closes
    always_comb begin
        w_acc_sum = r_acc + (in_valid ? SUM_W'(in_data) : '0);
        w_cnt_sum = r_cnt + CNT_W'(in_valid);
        w_close   = (w_cnt_sum == ACC_LEN_C) || (flush && (w_cnt_sum != '0));
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_acc   <= '0;
            r_cnt   <= '0;
            r_state <= IDLE;
        end else begin
            r_acc   <= w_close ? '0 : w_acc_sum;
            r_cnt   <= w_close ? '0 : w_cnt_sum;
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (in_valid && !w_close) w_state_nxt = ACCUM;
            ACCUM:   if (w_close) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // FIFO stage: a pop frees the slot a same-cycle push needs, so full+pop never drops
    always_comb begin
        w_empty = (r_wptr == r_rptr);
        w_full  = (r_wptr[PTR_W] != r_rptr[PTR_W]) &&
                  (r_wptr[PTR_W-1:0] == r_rptr[PTR_W-1:0]);
        w_pop   = !w_empty && out_ready;
        w_push  = w_close && (!w_full || w_pop);
        w_drop  = w_close && w_full && !w_pop;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            if (w_drop) r_overflow <= 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (w_push && !reset) begin
            r_mem_sum[r_wptr[PTR_W-1:0]] <= w_acc_sum;
            r_mem_cnt[r_wptr[PTR_W-1:0]] <= w_cnt_sum;
        end
    end

    always_comb begin
        out_valid = !w_empty;
        out_sum   = w_empty ? '0 : r_mem_sum[r_rptr[PTR_W-1:0]];
        out_count = w_empty ? '0 : r_mem_cnt[r_rptr[PTR_W-1:0]];
        overflow  = r_overflow;
    end

`ifdef MAC_COLLECTOR_DROPCNT_EN
    logic [15:0] r_drop_cnt;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_drop_cnt <= '0;
        end else if (w_drop && (r_drop_cnt != 16'hFFFF)) begin
            r_drop_cnt <= r_drop_cnt + 16'd1;
        end
    end

    assign drop_count = r_drop_cnt;
`endif

endmodule
